// File: rtl/icache_sa.sv
// Set-associative instruction cache: zero-latency hit lookup, multi-word block
// fill from the memory instruction channel, round-robin victim per set, flush.
module icache_sa #(
  parameter int CPUID = 0,
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int WOFF = $clog2(WORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - WOFF - IDXW;
  localparam int KW   = (WORDS > 1) ? WOFF : 1;
  localparam int VPW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [31:0] BLK_MASK = ~(32'(WORDS * 4) - 32'd1);
  localparam int unused_cpuid = CPUID;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]      state;
  logic [31:0]     base;
  logic [KW-1:0]   k;

  logic            valid [SETS][WAYS];
  logic [TAGW-1:0] tags  [SETS][WAYS];
  logic [31:0]     data  [SETS][WAYS][WORDS];
  logic [VPW-1:0]  vptr  [SETS];

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag_in;
  logic [KW-1:0]   wsel;
  logic            hit_any;
  logic [VPW-1:0]  hit_way;

  logic [IDXW-1:0] fidx;
  logic [TAGW-1:0] ftag;
  logic [VPW-1:0]  vict;
  logic            last;
  logic            unused_lsb;

  assign idx        = imemaddr[2+WOFF +: IDXW];
  assign tag_in     = imemaddr[31 -: TAGW];
  assign wsel       = (WORDS > 1) ? imemaddr[2 +: KW] : '0;
  assign fidx       = base[2+WOFF +: IDXW];
  assign ftag       = base[31 -: TAGW];
  assign vict       = vptr[fidx];
  assign last       = (k == KW'(WORDS - 1));
  assign unused_lsb = ^imemaddr[1:0];

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == tag_in) begin
        hit_any = 1'b1;
        hit_way = VPW'(w);
      end
    end
  end

  // Lookup only answers in IDLE; a flush in the same cycle suppresses it.
  assign ihit     = (state == IDLE) && imemREN && !flush && hit_any;
  assign imemload = ihit ? data[idx][hit_way][wsel] : '0;
  assign iREN     = (state == FETCH);
  assign iaddr    = (state == FETCH) ? (base + (32'(k) << 2)) : '0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      base       <= '0;
      k          <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        vptr[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
      end
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (flush) begin
        state <= IDLE;
        k     <= '0;
        for (int unsigned s = 0; s < SETS; s++)
          for (int unsigned w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (imemREN && !hit_any) begin
              base       <= imemaddr & BLK_MASK;
              k          <= '0;
              miss_count <= miss_count + 32'd1;
              state      <= FETCH;
            end
          end
          default: begin
            if (!iwait) begin
              if (last) begin
                tags[fidx][vict]  <= ftag;
                valid[fidx][vict] <= 1'b1;
                vptr[fidx]        <= (WAYS > 1) ? vict + VPW'(1) : '0;
                k                 <= '0;
                state             <= IDLE;
              end else begin
                k <= k + KW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // Data words carry no reset; a line is only trusted once its valid bit sets.
  always_ff @(posedge CLK) begin
    if (state == FETCH && !iwait) data[fidx][vict][k] <= iload;
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache for the per-CPU cache wrapper, sitting between the datapath fetch port and the memory controller's instruction channel. It supports configurable sets, ways and words per block, multi-word block fills, round-robin replacement, a synchronous flush, and hit/miss counters. Every instruction fetch is served from the cache arrays; misses stall the datapath until the block fill completes.

## Interface
Parameters:
- CPUID, 0, index of this CPU's channel on the memory controller arrays (used by the wrapper)
- SETS, 8, number of sets; power of two, ≥2
- WAYS, 2, associativity; one of 1, 2, 4
- WORDS, 2, 32-bit words per block; power of two, 1..8

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  byte address; bits [1:0] ignored
- ihit  out  1  fetch satisfied this cycle
- imemload  out  32  instruction word, valid when ihit=1, else 0
- flush  in  1  invalidate all lines
- iREN  out  1  memory read request
- iaddr  out  32  memory word address, word aligned
- iwait  in  1  memory busy; data not yet valid
- iload  in  32  memory read data
- hit_count  out  32  number of hit cycles
- miss_count  out  32  number of misses started

## Operation
- Address split, LSB first: 2 byte-offset bits, log2(WORDS) word-offset bits, log2(SETS) index bits, remaining bits tag.
- Storage per way per set: valid bit, tag, WORDS data words. There is one victim pointer per set, log2(WAYS) bits wide, for WAYS>1.
- Lookup (combinational, IDLE only): hit = imemREN and any way in the set has valid=1 and a matching tag.
  - On a hit: ihit=1 and imemload = the selected word of the matching way.
  - More than one way matching cannot occur by construction.
- States:
  - IDLE: no memory request. On imemREN and a miss, and flush=0: latch the block base (imemaddr with word/byte offsets cleared) and the index, set word counter k=0, increment miss_count, go to FETCH.
  - FETCH:
    - iREN=1 and iaddr = base + 4k.
    - When iwait=0, write iload into the victim way's word k.
    - If k=WORDS-1, also write the tag, set valid=1, advance the victim pointer modulo WAYS, and return to IDLE. Otherwise k increments.
- Replacement: the victim is the way selected by the set's pointer. Invalid ways are not preferred over the pointer choice, so the pointer alone decides.
- A fill is never aborted by imemREN or imemaddr changing. The latched block completes and the lookup is then redone with the current address.
- Flush:
  - In IDLE: all valid bits clear at the edge; ihit is forced to 0 that cycle.
  - In FETCH: flush aborts the fill, clears all valid bits, and returns to IDLE. Partial data is discarded and the line is not validated.
  - Victim pointers are not reset by flush.
- Counters:
  - hit_count increments on every cycle with ihit=1.
  - miss_count increments on each IDLE→FETCH transition.
  - Both wrap modulo 2^32.
- Reset (nRST=0 at an edge):
  - state IDLE, all valid bits 0, victim pointers 0, k=0, both counters 0.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
  - Reset mid-fill abandons the fill; reset has priority over flush.

## Timing
- Hit: zero-latency. ihit and imemload are asserted in the same cycle as imemREN.
- Miss: the miss is detected in cycle 0 and FETCH starts in cycle 1.
  - With iwait=0 throughout, word k is captured in cycle 1+k.
  - ihit is asserted in cycle WORDS+1. The default configuration gives 3 cycles.
  - Each iwait=1 cycle adds one cycle.
- iREN and iaddr are registered-state outputs. They are stable for the whole FETCH word and change only after a cycle with iwait=0.
- ihit=0 throughout FETCH, including the last fill cycle.
- Data written in FETCH is visible to the lookup on the next IDLE cycle.

## Test plan
- Cold miss at address 0x100 (WORDS=2, iwait=0):
  - iREN=1 with iaddr 0x100 in cycle 1 and 0x104 in cycle 2.
  - ihit=1 in cycle 3 with imemload = the word for 0x100.
  - A fetch of 0x104 then hits in zero cycles. miss_count=1, hit_count=2.
- Wait states: iwait=1 for 2 cycles on each word → iaddr is held, and ihit arrives in cycle 7 with correct data.
- Conflict (SETS=8, WAYS=2, block 8B): fill 0x000, 0x040, 0x080 in that order (all set 0).
  - The third fill evicts way 0 (0x000).
  - A refetch of 0x040 hits; a refetch of 0x000 misses.
- Flush:
  - Flush in IDLE after filling 0x100 → the next fetch of 0x100 misses.
  - Flush asserted in cycle 1 of a fill → iREN=0 the next cycle, the line stays invalid, and the refetch misses again.
- Address change mid-fill: imemaddr switches from 0x200 to 0x300 during FETCH.
  - The 0x200 block completes; then a miss on 0x300 starts and miss_count=2.
  - A later fetch of 0x200 hits.
- Reset asserted mid-fill → next cycle iREN=0, ihit=0, counters 0, and all previously filled lines miss.
